// File: rtl/ecdsa_sign_post.sv
// ECDSA signature post-processing: r = R.x mod n, s = kinv*(z + r*d) mod n, bit-serial.
// Optional build macro SIGN_POST_LOW_S_EN enables low-s normalization of s.
module ecdsa_sign_post (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] x_in,
    input  logic         inf_in,
    input  logic [255:0] z,
    input  logic [255:0] d,
    input  logic [255:0] kinv,
    output logic         busy,
    output logic         done,
    output logic [255:0] r,
    output logic [255:0] s,
    output logic         err
);
    // state  | meaning
    // IDLE   | waiting for start, operands latched on accept
    // REDUCE | reduce latched x and z below N
    // MUL1   | acc = r_reg * d mod N, MSB first
    // ADDZ   | z_reg = (z_reg + acc) mod N, acc cleared
    // MUL2   | acc = kinv * z_reg mod N
    // FINAL  | publish r, s, err and pulse done
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_REDUCE = 3'd1;
    localparam logic [2:0] ST_MUL1   = 3'd2;
    localparam logic [2:0] ST_ADDZ   = 3'd3;
    localparam logic [2:0] ST_MUL2   = 3'd4;
    localparam logic [2:0] ST_FINAL  = 3'd5;

    localparam logic [255:0] N      = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam logic [255:0] N_HALF = N >> 1;
    localparam logic [256:0] N_EXT  = {1'b0, N};

    logic [2:0]   state;
    logic [7:0]   cnt;
    logic [255:0] r_reg, z_reg, d_reg, kinv_reg, acc;
    logic         inf_reg;

    logic [256:0] dbl, dbl_red, mul_sum, add_sum;
    logic [255:0] mul_a, acc_next, u_next, r_red, z_red, s_final;
    logic         mul_bit;

    always_comb begin
        mul_a   = (state == ST_MUL2) ? z_reg : r_reg;
        mul_bit = (state == ST_MUL2) ? kinv_reg[cnt] : d_reg[cnt];
        dbl     = {acc, 1'b0};
        dbl_red = (dbl >= N_EXT) ? (dbl - N_EXT) : dbl;
        mul_sum = dbl_red + (mul_bit ? {1'b0, mul_a} : 257'd0);
        acc_next = (mul_sum >= N_EXT) ? 256'(mul_sum - N_EXT) : mul_sum[255:0];
        add_sum = {1'b0, z_reg} + {1'b0, acc};
        u_next  = (add_sum >= N_EXT) ? 256'(add_sum - N_EXT) : add_sum[255:0];
        r_red   = (r_reg >= N) ? (r_reg - N) : r_reg;
        z_red   = (z_reg >= N) ? (z_reg - N) : z_reg;
`ifdef SIGN_POST_LOW_S_EN
        s_final = (acc > N_HALF) ? (N - acc) : acc;
`else
        s_final = acc;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            r_reg    <= '0;
            z_reg    <= '0;
            d_reg    <= '0;
            kinv_reg <= '0;
            acc      <= '0;
            inf_reg  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r        <= '0;
            s        <= '0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        r_reg    <= x_in;
                        z_reg    <= z;
                        d_reg    <= d;
                        kinv_reg <= kinv;
                        inf_reg  <= inf_in;
                        busy     <= 1'b1;
                        state    <= ST_REDUCE;
                    end
                end
                ST_REDUCE: begin
                    r_reg <= r_red;
                    z_reg <= z_red;
                    acc   <= '0;
                    cnt   <= 8'd255;
                    state <= ST_MUL1;
                end
                ST_MUL1, ST_MUL2: begin
                    acc <= acc_next;
                    if (cnt == 8'd0)
                        state <= (state == ST_MUL1) ? ST_ADDZ : ST_FINAL;
                    else
                        cnt <= cnt - 8'd1;
                end
                ST_ADDZ: begin
                    z_reg <= u_next;
                    acc   <= '0;
                    cnt   <= 8'd255;
                    state <= ST_MUL2;
                end
                ST_FINAL: begin
                    r     <= r_reg;
                    s     <= s_final;
                    err   <= inf_reg | (r_reg == '0) | (s_final == '0);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ecdsa_sign_post.sv
// Directed bench for ecdsa_sign_post: latency, busy window, r/s/err values, restart and abort.
module tb_ecdsa_sign_post;
    localparam logic [255:0] N = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEBAAEDCE6AF48A03BBFD25E8CD0364141;
    localparam logic [255:0] ONES = {256{1'b1}};

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] x_in = '0;
    logic         inf_in = 1'b0;
    logic [255:0] z = '0;
    logic [255:0] d = '0;
    logic [255:0] kinv = '0;
    logic         busy, done, err;
    logic [255:0] r, s;

    int checks = 0;
    int failures = 0;

    ecdsa_sign_post dut (
        .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .inf_in(inf_in),
        .z(z), .d(d), .kinv(kinv), .busy(busy), .done(done), .r(r), .s(s), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // restart_at > 0: pulse start with x_in=9 after that many edges; abort_at > 0: assert reset then.
    task automatic run_job(input string tag, input logic [255:0] xv, input logic infv,
                           input logic [255:0] zv, input logic [255:0] dv, input logic [255:0] kv,
                           input logic [255:0] er, input logic [255:0] es, input logic eerr,
                           input int restart_at, input int abort_at);
        int edges;
        int busy_cnt;
        int done_cnt;
        @(negedge clk);
        x_in = xv; inf_in = infv; z = zv; d = dv; kinv = kv; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        x_in = ONES; z = 256'h1234; d = 256'h55; kinv = 256'h77; inf_in = ~infv;
        busy_cnt = int'(busy);
        edges = 0;
        while (edges < 1000) begin
            @(posedge clk);
            #1;
            edges++;
            start = 1'b0;
            if (done) break;
            busy_cnt += int'(busy);
            if (edges == restart_at) begin
                x_in = 256'd9; z = '0; d = 256'd1; kinv = 256'd1; start = 1'b1;
            end
            if (edges == abort_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, "_abort_busy"}, 256'(busy), 256'd0);
                check({tag, "_abort_r"}, r, '0);
                check({tag, "_abort_s"}, s, '0);
                check({tag, "_abort_err"}, 256'(err), 256'd0);
                repeat (3) @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                done_cnt = 0;
                repeat (600) begin
                    @(posedge clk);
                    #1;
                    done_cnt += int'(done);
                end
                check({tag, "_abort_no_done"}, 256'(done_cnt), 256'd0);
                return;
            end
        end
        check({tag, "_latency"}, 256'(edges), 256'd515);
        check({tag, "_busy_cycles"}, 256'(busy_cnt), 256'd515);
        check({tag, "_r"}, r, er);
        check({tag, "_s"}, s, es);
        check({tag, "_err"}, 256'(err), 256'(eerr));
    endtask

    logic [255:0] s_t2, s_t4, s_t6;

    initial begin
        #12;
        check("reset_busy", 256'(busy), 256'd0);
        check("reset_done", 256'(done), 256'd0);
        check("reset_r", r, '0);
        check("reset_s", s, '0);
        check("reset_err", 256'(err), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_job("basic", 256'd5, 1'b0, '0, 256'd1, 256'd1, 256'd5, 256'd5, 1'b0, 0, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", 256'(done), 256'd0);
        check("r_holds", r, 256'd5);

        // z reduces to 2^256-1-N; r*d = 6 keeps u below N
        s_t2 = ONES - N + 256'd6;
        run_job("reduce", N + 256'd3, 1'b0, ONES, 256'd2, 256'd1, 256'd3, s_t2, 1'b0, 0, 0);

        run_job("inf", '0, 1'b1, 256'd11, 256'd1, 256'd1, '0, 256'd11, 1'b1, 0, 0);

`ifdef SIGN_POST_LOW_S_EN
        s_t4 = 256'd1;
        s_t6 = 256'd2;
`else
        s_t4 = N - 256'd1;
        s_t6 = N - 256'd2;
`endif
        run_job("nm1", N - 256'd1, 1'b0, '0, 256'd1, 256'd1, N - 256'd1, s_t4, 1'b0, 0, 0);
        // (N-1)^2 mod N = 1
        run_job("sq", N - 256'd1, 1'b0, '0, N - 256'd1, 256'd1, N - 256'd1, 256'd1, 1'b0, 0, 0);
        // 2*(N-1) mod N = N-2
        run_job("kbig", 256'd2, 1'b0, '0, 256'd1, N - 256'd1, 256'd2, s_t6, 1'b0, 0, 0);

        run_job("restart", 256'd7, 1'b0, '0, 256'd1, 256'd1, 256'd7, 256'd7, 1'b0, 100, 0);
        run_job("b2b", 256'd13, 1'b0, 256'd4, 256'd1, 256'd1, 256'd13, 256'd17, 1'b0, 0, 0);

        run_job("abort", 256'd21, 1'b0, '0, 256'd1, 256'd1, '0, '0, 1'b0, 0, 300);
        run_job("fresh", 256'd6, 1'b0, 256'd1, 256'd3, 256'd2, 256'd6, 256'd38, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
